tick_counter: RTL
=================

// Module: tick_counter
// PURPOSE
//  Downstream consumer of the ripple clock divider. It samples the divided
//  clock (divider output q) in the fast system clock domain, detects its
//  rising edges, and drives a modulo-(MAX+1) up/down counter from them.
//  The counter supports synchronous load and a wrap pulse.
//  It also provides a 7-segment decode of the count for board display.
//  The whole block runs on one clock, so there is no logic clocked by q.
// PARAMETERS
//  WIDTH        4   counter width in bits
//  MAX          9   terminal count; legal range 1..2**WIDTH-1
//  SYNC_STAGES  2   flops in tick_in synchronizer; legal range >=2
// PORTS
//  clk       input   1      system clock, same clock feeding the divider
//  rstn      input   1      asynchronous reset, active-low
//  tick_in   input   1      divided clock from divider; treated as async
//  en        input   1      1 = detected edges step the counter
//  up        input   1      1 = count up, 0 = count down
//  load      input   1      synchronous load strobe
//  load_val  input   WIDTH  value loaded when load=1
//  count     output  WIDTH  registered counter value
//  carry     output  1      one-cycle pulse on wrap (MAX->0 up, 0->MAX down)
//  tick_seen output  1      one-cycle pulse per detected tick_in rising edge
//  seg       output  7      active-low {g,f,e,d,c,b,a} hex decode of count
// BEHAVIOUR
//  Reset (rstn=0, async): all of the following are 0:
//   - sync chain, edge reg, count, carry, tick_seen
//  The settle counter loads SYNC_STAGES+1, and seg=7'b1000000 (digit 0).
//  Sync: tick_in passes through SYNC_STAGES flops; edge reg holds last sync out.
//  Edge: step = sync_out & ~edge_reg & (settle==0).
//  Settle: decrements once per clk after rstn release until 0.
//  Edges are suppressed while settle!=0, so tick_in high at release is no step.
//  Latency: tick_in rise -> tick_seen/count update SYNC_STAGES+1 clk later.
//  A tick_in held high for any number of clk produces exactly one step.
//  tick_seen = step, registered; it pulses regardless of en and load.
//  Priority per clk, highest first:
//   load=1 : count <= (load_val>MAX) ? MAX : load_val; carry<=0; step is lost
//   step & en & up  : count==MAX ? (count<=0, carry<=1) : (count<=count+1)
//   step & en & ~up : count==0 ? (count<=MAX, carry<=1) : (count<=count-1)
//   otherwise       : count holds; carry<=0
//  carry is never high for two consecutive clk.
//  Direction changes take effect on the next step; no other state is kept.
//  seg: combinational decode of registered count, hex 0-F.
//  Any count>MAX is unreachable; decode still defined.
//  Reset mid-operation: count clears immediately.
//  An in-flight edge in the sync chain is discarded.
// TESTING
//  1. rstn=0 with tick_in toggling -> count=0, carry=0, tick_seen=0, seg=7'h40
//  2. MAX=9, en=1, up=1, 10 tick_in rises -> count 1..9,0
//     carry high exactly 1 clk at 9->0; each update SYNC_STAGES+1 clk after rise
//  3. count=0, up=0, one rise -> count=9, carry pulse; next rise -> count=8, no carry
//  4. load=1, load_val=12 (MAX=9) -> count=9
//     load coincident with step -> count=load_val, carry=0
//  5. tick_in held high 100 clk -> one step only
//     en=0 with 3 rises -> tick_seen pulses 3x, count unchanged
//  6. count=5, tick_in high, pulse rstn low mid-count -> count=0 at once
//     no step after release until tick_in falls and rises again

Source files
------------

// File: rtl/tick_counter.sv
// tick_counter
//   Samples a divided clock (tick_in) in the system clock domain, detects its
//   rising edges and steps a modulo-(MAX+1) up/down counter from them. Also
//   provides a synchronous load, a wrap pulse and an active-low 7-segment
//   decode of the count. Everything runs on clk; nothing is clocked by tick_in.
//
// Ports
//   clk        in   1      system clock
//   rstn       in   1      asynchronous reset, active-low
//   tick_in    in   1      divided clock, treated as asynchronous
//   en         in   1      1 = detected edges step the counter
//   up         in   1      1 = count up, 0 = count down
//   load       in   1      synchronous load strobe (highest priority)
//   load_val   in   WIDTH  load value, clamped to MAX
//   count      out  WIDTH  registered counter value
//   carry      out  1      one-clk pulse on wrap (MAX->0 up, 0->MAX down)
//   tick_seen  out  1      one-clk pulse per detected tick_in rising edge
//   seg        out  7      active-low {g,f,e,d,c,b,a} hex decode of count
module tick_counter #(
  parameter int WIDTH       = 4,
  parameter int MAX         = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick_in,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             tick_seen,
  output logic [6:0]       seg
);

  localparam int               SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic [SETTLE_W-1:0]    settle_q;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   carry_q, carry_d;
  logic                   tick_seen_q;
  logic                   sync_out;
  logic                   step;

  // Saturate a requested load value to the terminal count.
  function automatic logic [WIDTH-1:0] clamp_max(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Active-low {g,f,e,d,c,b,a} hex digit.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Edges are ignored until the synchronizer and edge register have been
  // refilled after reset, so a tick_in already high at release is not a step.
  assign step = sync_out & ~edge_q & (settle_q == '0);

  // Next count / carry, load wins over a coincident step.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (load) begin
      count_d = clamp_max(load_val);
    end else if (step && en) begin
      if (up) begin
        if (count_q == MAX_V) begin
          count_d = '0;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_V;
          carry_d = 1'b1;
        end else begin
          count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Synchronizer, edge detect and settle timer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q   <= '0;
      edge_q   <= 1'b0;
      settle_q <= SETTLE_INIT;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      edge_q <= sync_out;
      if (settle_q != '0) settle_q <= settle_q - 1'b1;
    end
  end

  // Counter and output pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q     <= '0;
      carry_q     <= 1'b0;
      tick_seen_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      carry_q     <= carry_d;
      tick_seen_q <= step;
    end
  end

  assign count     = count_q;
  assign carry     = carry_q;
  assign tick_seen = tick_seen_q;

  always_comb begin
    seg = hex_seg(4'(count_q));
  end

endmodule
